ro_puf_ctrl: RTL and testbench
==============================

# ro_puf_ctrl

Sequencing controller for the ring-oscillator array in the Root-of-Trust PUF. It accepts a challenge that names two oscillators and enables only that pair, letting them settle. It then counts their rising edges over a fixed clock window and emits one response bit saying which oscillator ran faster. It sits between the key-generation logic, which issues challenges and collects response bits, and the bank of enable-gated ring oscillators.

## Interface
Parameters:
- NUM_RO, 8: number of oscillators in the array; power of two, at least 2.
- SEL_W, $clog2(NUM_RO): width of one oscillator index.
- CNT_W, 16: edge-counter width.
- SETTLE, 4: number of cycles the pair runs before counting starts; at least 1.
- WINDOW, 1024: counting window in clk cycles; at least 1.

Ports:
- clk, in, 1: system clock; the single clock of the block.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request one evaluation; sampled only while busy=0.
- challenge, in, 2*SEL_W: bits [SEL_W-1:0] give index a, bits [2*SEL_W-1:SEL_W] give index b; sampled together with start.
- ro_out, in, NUM_RO: oscillator outputs, pre-divided to below clk/4 and asynchronous to clk.
- ro_en, out, NUM_RO: one-hot-pair enables driven to the oscillator enable pins.
- busy, out, 1: an evaluation is in progress.
- done, out, 1: one-cycle pulse; resp, tie and err are valid from this cycle on.
- resp, out, 1: response bit, 1 when cnt_a > cnt_b.
- tie, out, 1: cnt_a == cnt_b; resp is 0 in that case.
- err, out, 1: the challenge was rejected because a == b.
- cnt_a, out, CNT_W: final edge count of oscillator a.
- cnt_b, out, CNT_W: final edge count of oscillator b.

## Operation
- Reset values: all outputs are 0, ro_en is all-zero, and the FSM is in IDLE.
- FSM states are IDLE, SETTLE, COUNT, DRAIN and CMP.
- IDLE:
  - start=1 with a≠b: latch a and b, clear both counters, set ro_en[a] and ro_en[b], go to SETTLE.
  - start=1 with a==b: pulse err and done for one cycle, leave ro_en at zero, stay in IDLE.
- SETTLE: lasts SETTLE cycles, then go to COUNT. Counters are held at 0.
- COUNT: lasts WINDOW cycles. Each counter increments once per synchronized rising edge of its oscillator.
- DRAIN: lasts 2 cycles. ro_en is cleared on entry; counting continues so edges still in the synchronizers are flushed.
- CMP: lasts 1 cycle. resp, tie, cnt_a and cnt_b are registered, done pulses in the following cycle, and the FSM returns to IDLE.
- Edge detection: each oscillator uses a 2-flop synchronizer, a third flop, and detects a rising edge as sync & ~prev. Only the two selected channels are counted.
- Counters saturate at 2^CNT_W−1 and never wrap. Comparison is unsigned on the saturated values.
- resp, tie, err, cnt_a and cnt_b hold their values until the next accepted start.
- start while busy=1 is ignored, not queued.
- rst asserted mid-evaluation: ro_en drops to zero on the next edge, counts are discarded, and done does not pulse.
- Challenge indices are never out of range, because NUM_RO is a power of two.

## Timing
- start is sampled at edge k.
- busy is high from cycle k+1 to cycle k+SETTLE+WINDOW+3.
- ro_en is high from cycle k+1 to cycle k+SETTLE+WINDOW.
- done pulses at cycle k+SETTLE+WINDOW+4, with busy=0 in that same cycle.
- A new start is accepted from the done cycle onward.
- A rejected challenge (a==b) gives done and err at k+1, and busy never rises.

## Configuration
- Macro RO_PUF_MAJORITY_EN.
- When defined, each evaluation runs 3 full SETTLE/COUNT/DRAIN/CMP passes on the same pair:
  - Counters clear between passes.
  - resp is the majority of the three per-pass comparison bits.
  - tie is set if any pass tied; a tied pass votes 0.
  - cnt_a and cnt_b report the last pass.
  - done latency becomes 3·(SETTLE+WINDOW+3)+1 cycles.
- When undefined, the block performs a single pass with the latency given under Timing.

## Structure
- Package ro_puf_pkg holds the FSM state enum, the DRAIN length constant (2), and the challenge-field extraction helpers.
- Sub-module ro_edge_counter holds one channel: synchronizer, edge detector and saturating counter, with clear and count-enable inputs. The controller instantiates two of them, fed through NUM_RO:1 muxes on ro_out.

## Test plan
Parameters for all scenarios: NUM_RO=8, SETTLE=4, WINDOW=16, CNT_W=16. Oscillator models are clk-synchronous togglers gated by ro_en.
- Faster a: challenge a=1, b=6; ro1 has a period of 4 clk and ro6 a period of 8 clk. Expect done at k+24, resp=1, tie=0, cnt_a in 4..5, cnt_b in 2..3, and ro_en=8'b0100_0010 during cycles k+1..k+20.
- Faster b: swap the periods of scenario 1. Expect resp=0 and tie=0.
- Equal periods (both 8 clk, same phase): expect tie=1 and resp=0.
- Rejected challenge a=b=3: expect err=1 and done=1 at k+1, busy=0 throughout, and ro_en=0.
- Saturation with CNT_W=2 and ro1 period 4: expect cnt_a=3 with no wrap.
- Reset at k+10: expect ro_en=0 and busy=0 at k+11, no done pulse, and a later start that completes normally.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF controller: FSM state codes,
// drain length and helpers that split a challenge into its two indices.
package ro_puf_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETTLE = 3'd1;
    localparam state_t ST_COUNT  = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_CMP    = 3'd4;

    // Cycles spent flushing edges still in flight through the synchronizers.
    localparam int DRAIN_LEN = 2;

    function automatic logic [31:0] chal_a(input logic [31:0] ch, input int sel_w);
        return ch & ((32'd1 << sel_w) - 32'd1);
    endfunction

    function automatic logic [31:0] chal_b(input logic [31:0] ch, input int sel_w);
        return (ch >> sel_w) & ((32'd1 << sel_w) - 32'd1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One measurement channel: 2-flop synchronizer, rising-edge detector and a
// saturating edge counter with synchronous clear and count enable.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rise;

    assign rise = sync2_reg & ~prev_reg;
    assign cnt  = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= ro_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (clr) begin
                cnt_reg <= '0;
            end else if (en && rise && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencer: enables a challenged pair, settles, counts edges
// over a fixed window and reports which ran faster. RO_PUF_MAJORITY_EN selects a
// three-pass majority vote instead of a single pass.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO = 8,
    parameter int SEL_W  = $clog2(NUM_RO),
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4,
    parameter int WINDOW = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [NUM_RO-1:0]  ro_out,
    output logic [NUM_RO-1:0]  ro_en,
    output logic               busy,
    output logic               done,
    output logic               resp,
    output logic               tie,
    output logic               err,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [SEL_W-1:0] a_reg, b_reg, a_in, b_in;
    logic             en_reg, done_reg, resp_reg, tie_reg, err_reg;
    logic [CNT_W-1:0] cnt_a_reg, cnt_b_reg, cnt_a_w, cnt_b_w;
    logic             accept, reject, ctr_clr, ctr_en;
    logic             ro_a, ro_b, cmp_gt, cmp_eq;

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0] pass_reg;
    logic [1:0] votes_reg;
    logic [1:0] vote_sum;
    logic       tie_any_reg;
    assign vote_sum = votes_reg + {1'b0, cmp_gt};
`endif

    assign a_in = SEL_W'(chal_a(32'(challenge), SEL_W));
    assign b_in = SEL_W'(chal_b(32'(challenge), SEL_W));

    assign ro_a    = ro_out[a_reg];
    assign ro_b    = ro_out[b_reg];
    assign ctr_clr = accept | (state_reg == ST_SETTLE);
    assign ctr_en  = (state_reg == ST_COUNT) | (state_reg == ST_DRAIN);
    assign cmp_gt  = cnt_a_w > cnt_b_w;
    assign cmp_eq  = cnt_a_w == cnt_b_w;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_a),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .cnt   (cnt_a_w)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .ro_in (ro_b),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .cnt   (cnt_b_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RO; gi++) begin : g_en
            assign ro_en[gi] = en_reg & ((a_reg == SEL_W'(gi)) | (b_reg == SEL_W'(gi)));
        end
    endgenerate

    assign busy  = (state_reg != ST_IDLE);
    assign done  = done_reg;
    assign resp  = resp_reg;
    assign tie   = tie_reg;
    assign err   = err_reg;
    assign cnt_a = cnt_a_reg;
    assign cnt_b = cnt_b_reg;

    // Each timed state loads timer with its length minus one and leaves at zero.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (a_in != b_in) begin
                        accept     = 1'b1;
                        state_next = ST_SETTLE;
                        timer_next = TMR_W'(SETTLE - 1);
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_reg == '0) begin
                    state_next = ST_COUNT;
                    timer_next = TMR_W'(WINDOW - 1);
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_COUNT: begin
                if (timer_reg == '0) begin
                    state_next = ST_DRAIN;
                    timer_next = TMR_W'(DRAIN_LEN - 1);
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (timer_reg == '0) begin
                    state_next = ST_CMP;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_CMP: begin
`ifdef RO_PUF_MAJORITY_EN
                if (pass_reg != 2'd2) begin
                    state_next = ST_SETTLE;
                    timer_next = TMR_W'(SETTLE - 1);
                end else begin
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
            resp_reg  <= 1'b0;
            tie_reg   <= 1'b0;
            err_reg   <= 1'b0;
            cnt_a_reg <= '0;
            cnt_b_reg <= '0;
`ifdef RO_PUF_MAJORITY_EN
            pass_reg    <= '0;
            votes_reg   <= '0;
            tie_any_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            done_reg  <= 1'b0;
            if (accept) begin
                a_reg     <= a_in;
                b_reg     <= b_in;
                en_reg    <= 1'b1;
                err_reg   <= 1'b0;
                resp_reg  <= 1'b0;
                tie_reg   <= 1'b0;
                cnt_a_reg <= '0;
                cnt_b_reg <= '0;
`ifdef RO_PUF_MAJORITY_EN
                pass_reg    <= '0;
                votes_reg   <= '0;
                tie_any_reg <= 1'b0;
`endif
            end
            if (reject) begin
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
            end
            if ((state_reg == ST_COUNT) && (timer_reg == '0)) begin
                en_reg <= 1'b0;
            end
            if (state_reg == ST_CMP) begin
                cnt_a_reg <= cnt_a_w;
                cnt_b_reg <= cnt_b_w;
`ifdef RO_PUF_MAJORITY_EN
                if (pass_reg == 2'd2) begin
                    resp_reg <= vote_sum[1];
                    tie_reg  <= tie_any_reg | cmp_eq;
                    done_reg <= 1'b1;
                end else begin
                    pass_reg    <= pass_reg + 2'd1;
                    votes_reg   <= vote_sum;
                    tie_any_reg <= tie_any_reg | cmp_eq;
                    en_reg      <= 1'b1;
                end
`else
                resp_reg <= cmp_gt;
                tie_reg  <= cmp_eq;
                done_reg <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Randomized bench for ro_puf_ctrl: gated toggling oscillators, per-cycle
// handshake checks and a window-based edge-count reference model.
module tb_ro_puf_ctrl;

    localparam int NUM_RO   = 8;
    localparam int SEL_W    = 3;
    localparam int SETTLE   = 4;
    localparam int WINDOW   = 16;
    localparam int BUSY_LEN = SETTLE + WINDOW + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2*SEL_W-1:0] challenge = '0;
    logic [NUM_RO-1:0] ro_out = '0;

    logic [NUM_RO-1:0] ro_en, ro_en_s;
    logic              busy, done, resp, tie, err;
    logic              busy_s, done_s, resp_s, tie_s, err_s;
    logic [15:0]       cnt_a, cnt_b;
    logic [1:0]        cnt_a_s, cnt_b_s;

    ro_puf_ctrl #(.NUM_RO(NUM_RO), .CNT_W(16), .SETTLE(SETTLE), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_out(ro_out),
        .ro_en(ro_en), .busy(busy), .done(done), .resp(resp), .tie(tie), .err(err),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    // Narrow-counter twin fed the same stimulus, to exercise saturation.
    ro_puf_ctrl #(.NUM_RO(NUM_RO), .CNT_W(2), .SETTLE(SETTLE), .WINDOW(WINDOW)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_out(ro_out),
        .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .resp(resp_s), .tie(tie_s), .err(err_s),
        .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, edge_cnt);
        end
    endtask

    // Oscillators: toggle every half[i] cycles while enabled, parked low otherwise.
    int half [NUM_RO];
    int ph0  [NUM_RO];
    int ph   [NUM_RO];
    bit [NUM_RO-1:0] hist [0:8191];

    always @(negedge clk) begin
        for (int i = 0; i < NUM_RO; i++) begin
            if (!ro_en[i]) begin
                ro_out[i] = 1'b0;
                ph[i]     = ph0[i];
            end else if (ph[i] >= half[i] - 1) begin
                ro_out[i] = ~ro_out[i];
                ph[i]     = 0;
            end else begin
                ph[i] = ph[i] + 1;
            end
        end
        // hist[j] holds the oscillator value the DUT samples at edge j.
        if (edge_cnt < 8191) hist[edge_cnt + 1] = ro_out;
    end

    // A rise first sampled at edge j is counted at edge j+2 (two synchronizer
    // stages). Counting edges are those leaving COUNT/DRAIN: k+SETTLE+1 ..
    // k+SETTLE+WINDOW+2, so the sampled rises of interest are j in
    // k+SETTLE-1 .. k+SETTLE+WINDOW.
    function automatic int model_count(input int k, input int idx);
        int n = 0;
        for (int j = k + SETTLE - 1; j <= k + SETTLE + WINDOW; j++)
            if (hist[j][idx] && !hist[j-1][idx]) n++;
        return n;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    int last_ca = 0;
    int last_cb = 0;

    // Called at a negedge; drives start there so it is sampled at the next edge k.
    task automatic run_eval(input int a, input int b, input bit poke);
        int k, last, ca, cb;
        logic [NUM_RO-1:0] pair;
        start     = 1'b1;
        challenge = {3'(b), 3'(a)};
        k    = edge_cnt + 1;
        last = k + BUSY_LEN;
        pair = NUM_RO'((1 << a) | (1 << b));
        for (int m = k; m <= last; m++) begin
            @(negedge clk);
            if (poke && m == k + 5) begin
                start     = 1'b1;
                challenge = 6'($urandom);
            end else begin
                start = 1'b0;
            end
            check("ro_en", ro_en, (m <= k + SETTLE + WINDOW - 1) ? pair : '0);
            check("busy", busy, m <= k + SETTLE + WINDOW + 2);
            check("done", done, m == last);
        end
        ca = model_count(k, a);
        cb = model_count(k, b);
        check("cnt_a", cnt_a, ca);
        check("cnt_b", cnt_b, cb);
        check("resp", resp, ca > cb);
        check("tie", tie, ca == cb);
        check("err", err, 0);
        check("sat_done", done_s, 1);
        check("sat_cnt_a", cnt_a_s, sat3(ca));
        check("sat_cnt_b", cnt_b_s, sat3(cb));
        check("sat_resp", resp_s, sat3(ca) > sat3(cb));
        check("sat_tie", tie_s, sat3(ca) == sat3(cb));
        last_ca = ca;
        last_cb = cb;
        $display("eval a=%0d b=%0d k=%0d cnt_a=%0d cnt_b=%0d resp=%0b tie=%0b poke=%0b",
                 a, b, k, cnt_a, cnt_b, resp, tie, poke);
    endtask

    task automatic run_reject(input int a);
        start     = 1'b1;
        challenge = {3'(a), 3'(a)};
        @(negedge clk);
        start = 1'b0;
        check("rej_done", done, 1);
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_ro_en", ro_en, 0);
        check("rej_cnt_a_held", cnt_a, last_ca);
        check("rej_cnt_b_held", cnt_b, last_cb);
        @(negedge clk);
        check("rej_done_pulse", done, 0);
        check("rej_busy2", busy, 0);
        check("rej_err_held", err, 1);
        $display("reject a=b=%0d done/err observed at edge %0d", a, edge_cnt - 1);
    endtask

    task automatic run_reset_mid(input int a, input int b);
        int k;
        start     = 1'b1;
        challenge = {3'(b), 3'(a)};
        k = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt < k + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ro_en", ro_en, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_cnt_a", cnt_a, 0);
        for (int i = 0; i < BUSY_LEN + 4; i++) begin
            @(negedge clk);
            check("rstmid_no_done", done, 0);
            check("rstmid_idle", busy, 0);
        end
        last_ca = 0;
        last_cb = 0;
        $display("reset mid-evaluation a=%0d b=%0d at edge %0d", a, b, k + 10);
    endtask

    task automatic set_all(input int h, input int p);
        for (int i = 0; i < NUM_RO; i++) begin
            half[i] = h;
            ph0[i]  = p;
        end
    endtask

    initial begin
        int a, b;
        set_all(2, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ro_en", ro_en, 0);
        check("rst_resp", resp, 0);
        check("rst_tie", tie, 0);
        check("rst_err", err, 0);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Faster a (period 4 vs 8), then swapped, then equal.
        half[1] = 2; half[6] = 4;
        run_eval(1, 6, 1'b0);
        half[1] = 4; half[6] = 2;
        run_eval(1, 6, 1'b1);
        half[1] = 4; half[6] = 4;
        run_eval(1, 6, 1'b0);
        @(negedge clk);
        run_reject(3);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < NUM_RO; i++) begin
                half[i] = int'($urandom_range(2, 6));
                ph0[i]  = int'($urandom_range(0, half[i] - 1));
            end
            a = int'($urandom_range(0, NUM_RO - 1));
            b = (a + int'($urandom_range(1, NUM_RO - 1))) % NUM_RO;
            if (t % 5 == 4) run_reject(a);
            run_eval(a, b, 1'($urandom));
        end

        @(negedge clk);
        set_all(2, 0);
        run_reset_mid(2, 5);
        half[2] = 3; half[5] = 5;
        run_eval(2, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
